mdio_receptor_p: RTL and testbench
==================================

MDIO_RECEPTOR_P -- requirements
Module: mdio_receptor_p

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: PHY address this block responds to.
REQ-002 SHALL have parameter NUM_REGS, default 32, range 1..32: number of implemented 16-bit registers.
REQ-003 SHALL have parameter ID_REG, default 3: index of the read-only ID register.
REQ-004 SHALL have parameter ID_VALUE, default 16'h2AAA: reset and fixed content of ID_REG.
REQ-005 SHALL have parameter BCAST_EN, default 1: when 1, write frames to PHYAD 0 are also accepted.
REQ-006 SHALL have MDC  input  1  management clock; all logic on its rising edge.
REQ-007 SHALL have RESET  input  1  asynchronous, active-low reset.
REQ-008 SHALL have MDIO_OUT  input  1  serial data from the controller, sampled on MDC rising edge.
REQ-009 SHALL have MDIO_OE  input  1  controller drive enable; high marks controller-driven bits.
REQ-010 SHALL have MDIO_IN  output  1  serial read data to the controller.
REQ-011 SHALL have MDIO_IN_EN  output  1  high while this block drives MDIO_IN.
REQ-012 SHALL have ADDR  output  5  register address of the current/last frame.
REQ-013 SHALL have WR_DATA  output  16  write data of the current/last frame.
REQ-014 SHALL have WR_STB  output  1  one-cycle write commit pulse.
REQ-015 SHALL have MDIO_DONE  output  1  one-cycle end-of-accepted-frame pulse.
REQ-016 SHALL have FRAME_ERR  output  1  one-cycle pulse on malformed or aborted frame.

Function
REQ-017 Frame SHALL be 32 bits counted 0..31 by a 5-bit counter: ST 0-1 (01), OP 2-3 (01 write, 10 read), PHYAD 4-8, REGAD 9-13, TA 14-15, DATA 16-31, all fields MSB first.
REQ-018 States SHALL be IDLE, HDR, WDATA, RDATA, SKIP, DONE.
REQ-019 IDLE: first edge with MDIO_OE=1 samples bit 0 and enters HDR; otherwise stay IDLE.
REQ-020 HDR: at bit 1 if ST!=01, or at bit 3 if OP is 00 or 11 -> FRAME_ERR pulse, enter IDLE.
REQ-021 HDR: at bit 13, PHYAD mismatch (not PHY_ADDR, and not broadcast write with BCAST_EN=1) -> SKIP; else ADDR<=REGAD, enter WDATA (write) or RDATA (read).
REQ-022 SKIP SHALL count to bit 31 with no output activity besides counting, then enter IDLE; no FRAME_ERR, no MDIO_DONE.
REQ-023 WDATA: WR_DATA[31-n]<=MDIO_OUT at bit n=16..31; after bit 31 enter DONE.
REQ-024 DONE (one MDC cycle): MDIO_DONE=1; for a write WR_STB=1 with ADDR/WR_DATA stable; register written at the edge ending DONE; next state IDLE unconditionally.
REQ-025 Write to ADDR>=NUM_REGS or ADDR==ID_REG SHALL still pulse WR_STB and MDIO_DONE but SHALL NOT change any register.
REQ-026 RDATA: after edge of bit 14, MDIO_IN_EN=1, MDIO_IN=0 (TA zero); after edge of bit 15+k (k=0..15) MDIO_IN=RD[15-k]; after edge of bit 31 MDIO_IN_EN=0, MDIO_IN=0, enter DONE.
REQ-027 RD SHALL be captured at bit 14 edge; ADDR>=NUM_REGS reads 16'h0000.
REQ-028 MDIO_OE=0 during HDR or WDATA SHALL abort: FRAME_ERR pulse, no WR_STB, no register change, enter IDLE; MDIO_OE is ignored in RDATA, SKIP, DONE.
REQ-029 MDIO_IN_EN SHALL never be high outside RDATA.
REQ-030 ADDR and WR_DATA SHALL hold their values after a frame until the next accepted frame updates them.

Reset
REQ-031 RESET low SHALL immediately force state IDLE, counter 0, MDIO_IN=0, MDIO_IN_EN=0, ADDR=0, WR_DATA=0, WR_STB=0, MDIO_DONE=0, FRAME_ERR=0.
REQ-032 RESET low SHALL clear all registers to 0 except ID_REG, which SHALL be ID_VALUE.
REQ-033 Reset mid-frame SHALL discard the frame without a write; the first frame after release SHALL decode normally.

Verification
REQ-034 Write 0x1234 to PHYAD 1, REGAD 5, then read REGAD 5 -> one WR_STB with ADDR=5, WR_DATA=0x1234; read MDIO_IN stream 0,then 0x1234 MSB first; MDIO_DONE once per frame.
REQ-035 Read REGAD 3 after reset -> 0x2AAA; write 0xFFFF to REGAD 3, reread -> still 0x2AAA.
REQ-036 Write to PHYAD 7 -> SKIP, no WR_STB/MDIO_DONE/FRAME_ERR; write to PHYAD 0 with BCAST_EN=1 -> accepted.
REQ-037 ST=00 frame -> FRAME_ERR at bit 1; OP=11 -> FRAME_ERR at bit 3; MDIO_OE low at bit 20 of write -> FRAME_ERR, register unchanged.
REQ-038 NUM_REGS=8: read REGAD 12 -> 0x0000; write REGAD 12 -> WR_STB but no register change.
REQ-039 RESET pulsed at bit 25 of write to REGAD 2 -> outputs zero immediately, REGAD 2 reads 0x0000 afterward.

Source files
------------

// File: rtl/mdio_receptor_p.sv
// -----------------------------------------------------------------------------
// mdio_receptor_p
//
// Purpose:
//   MDIO (clause-22 style) management slave. Decodes 32-bit frames from a
//   management controller on the rising edge of MDC. It exposes the decoded
//   register address and write data, and it keeps a small bank of 16-bit
//   registers. Read frames are answered on MDIO_IN. One register is a
//   read-only ID register.
//
//   Frame bits (counted 0..31, every field MSB first):
//     ST 0-1 (01) | OP 2-3 (01 wr, 10 rd) | PHYAD 4-8 | REGAD 9-13 |
//     TA 14-15 | DATA 16-31
//
// Ports:
//   MDC         in   management clock; all logic runs on its rising edge
//   RESET       in   asynchronous reset, active low
//   MDIO_OUT    in   serial data from the controller
//   MDIO_OE     in   controller drive enable (high = controller-driven bit)
//   MDIO_IN     out  serial read data to the controller
//   MDIO_IN_EN  out  high while this block drives MDIO_IN
//   ADDR        out  register address of the current/last accepted frame
//   WR_DATA     out  write data of the current/last accepted frame
//   WR_STB      out  one-cycle write commit pulse
//   MDIO_DONE   out  one-cycle end-of-accepted-frame pulse
//   FRAME_ERR   out  one-cycle pulse on a malformed or aborted frame
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mdio_receptor_p #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int          NUM_REGS = 32,
    parameter int          ID_REG   = 3,
    parameter logic [15:0] ID_VALUE = 16'h2AAA,
    parameter bit          BCAST_EN = 1'b1
) (
    input  logic        MDC,
    input  logic        RESET,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_EN,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        MDIO_DONE,
    output logic        FRAME_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        RDATA,
        SKIP,
        DONE
    } state_t;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;       // index of the bit sampled at the next MDC edge
    logic [10:0] sh_q;        // the most recent header bits, newest in [0]
    logic        wr_q;        // accepted frame is a write
    logic [15:0] rd_q;        // read data, shifted out MSB first
    logic        err_d;

    logic [15:0] regs [NUM_REGS];
    logic [15:0] rd_mux;

    // Header fields as seen at the edge that samples bit 13. sh_q then holds
    // bits 2..12, and bit 13 is the live MDIO_OUT.
    logic [1:0]  op_f;
    logic [4:0]  phyad_f;
    logic [4:0]  regad_f;
    logic        addr_hit;

    assign op_f     = sh_q[10:9];
    assign phyad_f  = sh_q[8:4];
    assign regad_f  = {sh_q[3:0], MDIO_OUT};
    assign addr_hit = (phyad_f == PHY_ADDR) ||
                      (BCAST_EN && (phyad_f == 5'd0) && (op_f == OP_WR));

    // Register read mux; an address past the implemented bank reads zero.
    always_comb begin
        rd_mux = 16'h0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ADDR == i[4:0]) rd_mux = regs[i];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and Moore outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        MDIO_DONE = 1'b0;
        WR_STB    = 1'b0;

        case (state_q)
            IDLE: begin
                if (MDIO_OE) state_d = HDR;
            end

            HDR: begin
                if (!MDIO_OE) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 5'd1 && {sh_q[0], MDIO_OUT} != 2'b01) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 5'd3 &&
                             ({sh_q[0], MDIO_OUT} == 2'b00 ||
                              {sh_q[0], MDIO_OUT} == 2'b11)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 5'd13) begin
                    if (!addr_hit)           state_d = SKIP;
                    else if (op_f == OP_RD)  state_d = RDATA;
                    else                     state_d = WDATA;
                end
            end

            WDATA: begin
                if (!MDIO_OE) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end

            RDATA: begin
                if (cnt_q == 5'd31) state_d = DONE;
            end

            SKIP: begin
                if (cnt_q == 5'd31) state_d = IDLE;
            end

            DONE: begin
                MDIO_DONE = 1'b1;
                WR_STB    = wr_q;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and frame datapath
    // -------------------------------------------------------------------------
    // NOTE: clocked state is updated with non-blocking assignments only, so
    // every process reads the values from before the edge.
    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            sh_q       <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 16'h0000;
            ADDR       <= 5'd0;
            WR_DATA    <= 16'h0000;
            MDIO_IN    <= 1'b0;
            MDIO_IN_EN <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state_q   <= state_d;
            FRAME_ERR <= err_d;

            // The counter follows the frame. It restarts whenever the frame
            // ends or is abandoned, so DONE and IDLE always hold 0.
            cnt_q <= (state_d == IDLE || state_d == DONE) ? 5'd0 : cnt_q + 5'd1;

            if (state_q == IDLE || state_q == HDR) begin
                sh_q <= {sh_q[9:0], MDIO_OUT};
            end

            if (state_q == HDR && (state_d == WDATA || state_d == RDATA)) begin
                ADDR <= regad_f;
                wr_q <= (state_d == WDATA);
            end

            // Data bits 16..31 map to WR_DATA[15..0]; 31-n is ~n[3:0] there.
            if (state_q == WDATA && MDIO_OE && cnt_q[4]) begin
                WR_DATA[~cnt_q[3:0]] <= MDIO_OUT;
            end

            if (state_q == RDATA) begin
                if (cnt_q == 5'd14) begin
                    // Snapshot the register and drive the zero turnaround bit.
                    rd_q       <= rd_mux;
                    MDIO_IN_EN <= 1'b1;
                    MDIO_IN    <= 1'b0;
                end else if (cnt_q == 5'd31) begin
                    MDIO_IN_EN <= 1'b0;
                    MDIO_IN    <= 1'b0;
                end else begin
                    MDIO_IN <= rd_q[15];
                    rd_q    <= {rd_q[14:0], 1'b0};
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Register bank. A write commits at the edge that ends DONE. The ID
    // register and addresses past the bank ignore writes.
    // -------------------------------------------------------------------------
    // NOTE: this bank is a set of individually reset flops rather than a RAM.
    // Reset must load known contents (the ID value in particular), and a RAM
    // macro could not be cleared asynchronously.
    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == ID_REG) ? ID_VALUE : 16'h0000;
            end
        end else if (WR_STB) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i != ID_REG && ADDR == i[4:0]) regs[i] <= WR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_mdio_receptor_p.sv
// -----------------------------------------------------------------------------
// tb_mdio_receptor_p
//
// Self-checking bench for mdio_receptor_p, built with an 8-register bank.
// Expected write strobes and read words go into scoreboard queues when a
// frame is driven. A monitor collects what the DUT produces. Each test task
// pops the scoreboard and compares it with the collected results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mdio_receptor_p;

    localparam int NREG = 8;

    logic        MDC = 1'b0;
    logic        RESET = 1'b0;
    logic        MDIO_OUT = 1'b0;
    logic        MDIO_OE = 1'b0;
    logic        MDIO_IN;
    logic        MDIO_IN_EN;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        MDIO_DONE;
    logic        FRAME_ERR;

    int checks = 0;
    int failures = 0;

    // Bench model and scoreboard
    logic [15:0] model [32];
    logic [20:0] exp_wr [$];
    logic [15:0] exp_rd [$];

    // Monitor observations
    logic [20:0] wr_obs [$];
    logic [15:0] rd_obs [$];
    int          cur_bit = -1;
    int          done_cnt, err_cnt, err_bit, en_cnt;
    logic        ta_bad;
    logic [15:0] rd_word;

    mdio_receptor_p #(
        .PHY_ADDR (5'd1),
        .NUM_REGS (NREG),
        .ID_REG   (3),
        .ID_VALUE (16'h2AAA),
        .BCAST_EN (1'b1)
    ) dut (
        .MDC        (MDC),
        .RESET      (RESET),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .MDIO_IN    (MDIO_IN),
        .MDIO_IN_EN (MDIO_IN_EN),
        .ADDR       (ADDR),
        .WR_DATA    (WR_DATA),
        .WR_STB     (WR_STB),
        .MDIO_DONE  (MDIO_DONE),
        .FRAME_ERR  (FRAME_ERR)
    );

    always #5 MDC = ~MDC;

    // Sample just after each rising edge; cur_bit names the bit of that edge.
    always @(posedge MDC) begin
        #1;
        if (WR_STB) wr_obs.push_back({ADDR, WR_DATA});
        if (MDIO_DONE) done_cnt++;
        if (FRAME_ERR) begin
            err_cnt++;
            err_bit = cur_bit;
        end
        if (MDIO_IN_EN) begin
            en_cnt++;
            if (cur_bit == 14) begin
                if (MDIO_IN !== 1'b0) ta_bad = 1'b1;
            end else begin
                rd_word = {rd_word[14:0], MDIO_IN};
                if (cur_bit == 30) rd_obs.push_back(rd_word);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 16'h0000;
        model[3] = 16'h2AAA;
    endtask

    task automatic clear_mon();
        done_cnt = 0;
        err_cnt  = 0;
        err_bit  = -1;
        en_cnt   = 0;
        ta_bad   = 1'b0;
        rd_word  = 16'h0000;
    endtask

    task automatic get_wr(output logic [20:0] got);
        if (wr_obs.size() != 0) got = wr_obs.pop_front();
        else                    got = 'x;
    endtask

    task automatic get_rd(output logic [15:0] got);
        if (rd_obs.size() != 0) got = rd_obs.pop_front();
        else                    got = 'x;
    endtask

    // Drive frame bits 0..last_bit, then three idle cycles. A read releases
    // MDIO_OE from the turnaround on. If abort_last is set, MDIO_OE drops on
    // last_bit.
    task automatic send(input logic [1:0] st, input logic [1:0] op,
                        input logic [4:0] phy, input logic [4:0] ra,
                        input logic [15:0] data, input int last_bit,
                        input bit abort_last);
        logic [31:0] w;
        w = {st, op, phy, ra, 2'b10, data};
        for (int n = 0; n <= last_bit; n++) begin
            @(negedge MDC);
            cur_bit  = n;
            MDIO_OUT = w[31-n];
            MDIO_OE  = (op == 2'b10 && n >= 14) ? 1'b0 : 1'b1;
            if (abort_last && n == last_bit) MDIO_OE = 1'b0;
        end
        repeat (3) begin
            @(negedge MDC);
            cur_bit  = -1;
            MDIO_OE  = 1'b0;
            MDIO_OUT = 1'b0;
        end
    endtask

    task automatic do_write(input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] data, input bit accepted);
        clear_mon();
        if (accepted) begin
            exp_wr.push_back({ra, data});
            if (ra < NREG && ra != 5'd3) model[ra] = data;
        end
        send(2'b01, 2'b01, phy, ra, data, 31, 1'b0);
    endtask

    task automatic do_read(input logic [4:0] phy, input logic [4:0] ra,
                           input bit accepted);
        clear_mon();
        if (accepted) exp_rd.push_back((ra < NREG) ? model[ra] : 16'h0000);
        send(2'b01, 2'b10, phy, ra, 16'h0000, 31, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        RESET = 1'b0;
        repeat (3) @(negedge MDC);
        checks++;
        if ({MDIO_IN, MDIO_IN_EN, ADDR, WR_DATA, WR_STB, MDIO_DONE, FRAME_ERR} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: got in=%b en=%b addr=%h wd=%h stb=%b done=%b err=%b, want all zero",
                     MDIO_IN, MDIO_IN_EN, ADDR, WR_DATA, WR_STB, MDIO_DONE, FRAME_ERR);
        end
        RESET = 1'b1;
        repeat (2) @(negedge MDC);
    endtask

    task automatic test_write_read();
        logic [20:0] gw, ww;
        logic [15:0] gr, wr;
        do_write(5'd1, 5'd5, 16'h1234, 1'b1);
        get_wr(gw);
        ww = exp_wr.pop_front();
        checks++;
        if (gw !== ww) begin failures++; $display("FAIL wr5_strobe: got %h want %h", gw, ww); end
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0 || wr_obs.size() != 0) begin
            failures++;
            $display("FAIL wr5_pulses: got done=%0d err=%0d extra_stb=%0d want 1 0 0", done_cnt, err_cnt, wr_obs.size());
        end

        do_read(5'd1, 5'd5, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL rd5_data: got %h want %h", gr, wr); end
        checks++;
        if (en_cnt !== 17 || ta_bad !== 1'b0) begin
            failures++;
            $display("FAIL rd5_drive: got en_cycles=%0d ta_bad=%b want 17 0", en_cnt, ta_bad);
        end
        checks++;
        if (done_cnt !== 1 || wr_obs.size() != 0) begin
            failures++;
            $display("FAIL rd5_pulses: got done=%0d stb=%0d want 1 0", done_cnt, wr_obs.size());
        end
        checks++;
        if ({ADDR, WR_DATA} !== {5'd5, 16'h1234}) begin
            failures++;
            $display("FAIL hold_after_read: got addr=%h wd=%h want 05 1234", ADDR, WR_DATA);
        end
    endtask

    task automatic test_id_reg();
        logic [20:0] gw, ww;
        logic [15:0] gr, wr;
        do_read(5'd1, 5'd3, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL id_value: got %h want %h", gr, wr); end

        do_write(5'd1, 5'd3, 16'hFFFF, 1'b1);
        get_wr(gw);
        ww = exp_wr.pop_front();
        checks++;
        if (gw !== ww || done_cnt !== 1) begin
            failures++;
            $display("FAIL id_write_strobe: got %h done=%0d want %h done=1", gw, done_cnt, ww);
        end

        do_read(5'd1, 5'd3, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL id_read_only: got %h want %h", gr, wr); end
    endtask

    task automatic test_skip_bcast();
        logic [20:0] gw, ww;
        logic [15:0] gr, wr;
        do_write(5'd7, 5'd6, 16'hBAD0, 1'b0);
        checks++;
        if (wr_obs.size() != 0 || done_cnt !== 0 || err_cnt !== 0) begin
            failures++;
            $display("FAIL skip_write_quiet: got stb=%0d done=%0d err=%0d want 0 0 0", wr_obs.size(), done_cnt, err_cnt);
        end
        checks++;
        if (ADDR !== 5'd3) begin failures++; $display("FAIL skip_addr_hold: got %h want 03", ADDR); end

        do_read(5'd7, 5'd5, 1'b0);
        checks++;
        if (en_cnt !== 0 || done_cnt !== 0 || err_cnt !== 0) begin
            failures++;
            $display("FAIL skip_read_quiet: got en=%0d done=%0d err=%0d want 0 0 0", en_cnt, done_cnt, err_cnt);
        end

        do_write(5'd0, 5'd6, 16'hA55A, 1'b1);
        get_wr(gw);
        ww = exp_wr.pop_front();
        checks++;
        if (gw !== ww || done_cnt !== 1) begin
            failures++;
            $display("FAIL bcast_write: got %h done=%0d want %h done=1", gw, done_cnt, ww);
        end

        do_read(5'd1, 5'd6, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL bcast_readback: got %h want %h", gr, wr); end

        do_read(5'd0, 5'd6, 1'b0);
        checks++;
        if (en_cnt !== 0 || done_cnt !== 0) begin
            failures++;
            $display("FAIL bcast_read_ignored: got en=%0d done=%0d want 0 0", en_cnt, done_cnt);
        end
    endtask

    task automatic test_errors();
        logic [15:0] gr, wr;
        clear_mon();
        send(2'b00, 2'b01, 5'd1, 5'd5, 16'h0000, 1, 1'b0);
        checks++;
        if (err_cnt !== 1 || err_bit !== 1 || done_cnt !== 0) begin
            failures++;
            $display("FAIL st_error: got err=%0d at bit %0d done=%0d want 1 at bit 1 done=0", err_cnt, err_bit, done_cnt);
        end

        clear_mon();
        send(2'b01, 2'b11, 5'd1, 5'd5, 16'h0000, 3, 1'b0);
        checks++;
        if (err_cnt !== 1 || err_bit !== 3 || done_cnt !== 0) begin
            failures++;
            $display("FAIL op_error: got err=%0d at bit %0d done=%0d want 1 at bit 3 done=0", err_cnt, err_bit, done_cnt);
        end

        clear_mon();
        send(2'b01, 2'b01, 5'd1, 5'd5, 16'hDEAD, 20, 1'b1);
        checks++;
        if (err_cnt !== 1 || err_bit !== 20 || done_cnt !== 0 || wr_obs.size() != 0) begin
            failures++;
            $display("FAIL abort_error: got err=%0d at bit %0d done=%0d stb=%0d want 1 at bit 20 done=0 stb=0",
                     err_cnt, err_bit, done_cnt, wr_obs.size());
        end

        do_read(5'd1, 5'd5, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL abort_no_change: got %h want %h", gr, wr); end
    endtask

    task automatic test_out_of_range();
        logic [20:0] gw, ww;
        logic [15:0] gr, wr;
        do_read(5'd1, 5'd12, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL oob_read: got %h want %h", gr, wr); end

        do_write(5'd1, 5'd12, 16'h7777, 1'b1);
        get_wr(gw);
        ww = exp_wr.pop_front();
        checks++;
        if (gw !== ww || done_cnt !== 1) begin
            failures++;
            $display("FAIL oob_write_strobe: got %h done=%0d want %h done=1", gw, done_cnt, ww);
        end

        do_read(5'd1, 5'd12, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL oob_reread: got %h want %h", gr, wr); end

        do_read(5'd1, 5'd4, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL oob_no_alias: got %h want %h", gr, wr); end
    endtask

    task automatic test_reset_mid_frame();
        logic [20:0] gw, ww;
        logic [15:0] gr, wr;
        logic [31:0] w;

        do_write(5'd1, 5'd2, 16'h5A5A, 1'b1);
        get_wr(gw);
        ww = exp_wr.pop_front();
        checks++;
        if (gw !== ww) begin failures++; $display("FAIL pre_reset_write: got %h want %h", gw, ww); end

        clear_mon();
        w = {2'b01, 2'b01, 5'd1, 5'd2, 2'b10, 16'hC3A5};
        for (int n = 0; n <= 25; n++) begin
            @(negedge MDC);
            cur_bit  = n;
            MDIO_OUT = w[31-n];
            MDIO_OE  = 1'b1;
        end
        @(posedge MDC);
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if ({MDIO_IN, MDIO_IN_EN, ADDR, WR_DATA, WR_STB, MDIO_DONE, FRAME_ERR} !== 26'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got in=%b en=%b addr=%h wd=%h stb=%b done=%b err=%b, want all zero",
                     MDIO_IN, MDIO_IN_EN, ADDR, WR_DATA, WR_STB, MDIO_DONE, FRAME_ERR);
        end
        model_reset();
        @(negedge MDC);
        cur_bit  = -1;
        MDIO_OE  = 1'b0;
        MDIO_OUT = 1'b0;
        repeat (2) @(negedge MDC);
        RESET = 1'b1;
        @(negedge MDC);

        do_read(5'd1, 5'd2, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr || wr_obs.size() != 0) begin
            failures++;
            $display("FAIL post_reset_reg2: got %h stb=%0d want %h stb=0", gr, wr_obs.size(), wr);
        end

        do_read(5'd1, 5'd3, 1'b1);
        get_rd(gr);
        wr = exp_rd.pop_front();
        checks++;
        if (gr !== wr) begin failures++; $display("FAIL post_reset_id: got %h want %h", gr, wr); end
    endtask

    initial begin
        model_reset();
        clear_mon();
        test_reset();
        test_write_read();
        test_id_reg();
        test_skip_bcast();
        test_errors();
        test_out_of_range();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
